// File: rtl/ahb_timer_pkg.sv
// Shared definitions for ahb_timer: register offsets, CONTROL bit positions
// and the prescale-select encoding.
package ahb_timer_pkg;

    localparam logic [7:0] TMR_LOAD_OFS   = 8'h00;
    localparam logic [7:0] TMR_VALUE_OFS  = 8'h04;
    localparam logic [7:0] TMR_CTRL_OFS   = 8'h08;
    localparam logic [7:0] TMR_INTCLR_OFS = 8'h0C;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_ONESHOT_BIT = 1;
    localparam int CTRL_PSC_LSB     = 2;
    localparam int CTRL_PSC_MSB     = 3;
    localparam int CTRL_IRQEN_BIT   = 4;

    typedef enum logic [1:0] {
        PSC_DIV1   = 2'b00,
        PSC_DIV16  = 2'b01,
        PSC_DIV256 = 2'b10,
        PSC_RSVD   = 2'b11
    } psc_sel_e;

    // Terminal count (divisor - 1); the reserved encoding behaves as divide-by-1.
    function automatic logic [7:0] psc_terminal(input psc_sel_e sel);
        case (sel)
            PSC_DIV16:  return 8'd15;
            PSC_DIV256: return 8'd255;
            default:    return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_timer_prescaler.sv
// Clock prescaler for ahb_timer; emits a one-cycle tick every 1/16/256 cycles.
// Only instantiated when AHB_TIMER_PRESCALE_EN is defined.
module ahb_timer_prescaler
    import ahb_timer_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     enable,
    input  logic     clear,
    input  psc_sel_e sel,
    output logic     tick
);

    logic [7:0] count;
    logic [7:0] terminal;

    assign terminal = psc_terminal(sel);
    assign tick     = enable && (count == terminal);

    // Count is held at zero while disabled, so re-enabling starts a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!enable || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/ahb_timer.sv
// AHB-Lite 32-bit down-counting timer with periodic/one-shot modes and sticky IRQ.
// Define AHB_TIMER_PRESCALE_EN to build in the selectable clock prescaler.
module ahb_timer
    import ahb_timer_pkg::*;
#(
    parameter int          ADDR_W     = 4,
    parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        timer_irq
);

    localparam logic [ADDR_W-3:0] IDX_LOAD   = TMR_LOAD_OFS[ADDR_W-1:2];
    localparam logic [ADDR_W-3:0] IDX_VALUE  = TMR_VALUE_OFS[ADDR_W-1:2];
    localparam logic [ADDR_W-3:0] IDX_CTRL   = TMR_CTRL_OFS[ADDR_W-1:2];
    localparam logic [ADDR_W-3:0] IDX_INTCLR = TMR_INTCLR_OFS[ADDR_W-1:2];

    logic [ADDR_W-3:0] addr_q;
    logic              write_q;
    logic              valid_q;

    logic [31:0] load_q;
    logic [31:0] value_q;
    logic        irq_flag;
    logic        ctrl_en;
    logic        ctrl_oneshot;
    logic        ctrl_irq_en;
    psc_sel_e    psc_sel;

    logic wr_en, wr_load, wr_ctrl, wr_intclr;
    logic tick, expire;
    logic unused_bits;

    assign unused_bits = ^{HSIZE, HADDR[31:ADDR_W], HADDR[1:0]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign timer_irq = irq_flag & ctrl_irq_en;

    // Address phase capture
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= HSEL & HREADY & HTRANS[1];
            if (HSEL & HREADY & HTRANS[1]) begin
                addr_q  <= HADDR[ADDR_W-1:2];
                write_q <= HWRITE;
            end
        end
    end

    assign wr_en     = valid_q & write_q;
    assign wr_load   = wr_en && (addr_q == IDX_LOAD);
    assign wr_ctrl   = wr_en && (addr_q == IDX_CTRL);
    assign wr_intclr = wr_en && (addr_q == IDX_INTCLR);
    assign expire    = tick && (value_q == '0);

`ifdef AHB_TIMER_PRESCALE_EN
    ahb_timer_prescaler u_prescaler (
        .clk    (HCLK),
        .rst_n  (HRESETn),
        .enable (ctrl_en),
        .clear  (wr_load),
        .sel    (psc_sel),
        .tick   (tick)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            psc_sel <= PSC_DIV1;
        end else if (wr_ctrl) begin
            psc_sel <= psc_sel_e'(HWDATA[CTRL_PSC_MSB:CTRL_PSC_LSB]);
        end
    end
`else
    assign tick    = ctrl_en;
    assign psc_sel = PSC_DIV1;
`endif

    // A bus write to CONTROL takes precedence over the one-shot auto-disable.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl_en      <= 1'b0;
            ctrl_oneshot <= 1'b0;
            ctrl_irq_en  <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en      <= HWDATA[CTRL_EN_BIT];
            ctrl_oneshot <= HWDATA[CTRL_ONESHOT_BIT];
            ctrl_irq_en  <= HWDATA[CTRL_IRQEN_BIT];
        end else if (expire && ctrl_oneshot) begin
            ctrl_en <= 1'b0;
        end
    end

    // Counter: a LOAD write overrides any tick in the same cycle; flag set beats clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            load_q   <= RESET_LOAD;
            value_q  <= RESET_LOAD;
            irq_flag <= 1'b0;
        end else begin
            if (wr_load) begin
                load_q  <= HWDATA;
                value_q <= HWDATA;
            end else if (tick) begin
                if (value_q != '0) begin
                    value_q <= value_q - 32'd1;
                end else if (!ctrl_oneshot) begin
                    value_q <= load_q;
                end
            end
            if (expire) begin
                irq_flag <= 1'b1;
            end else if (wr_intclr) begin
                irq_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        if (valid_q && !write_q) begin
            case (addr_q)
                IDX_LOAD:   HRDATA = load_q;
                IDX_VALUE:  HRDATA = value_q;
                IDX_CTRL:   HRDATA = {27'b0, ctrl_irq_en, psc_sel, ctrl_oneshot, ctrl_en};
                IDX_INTCLR: HRDATA = {31'b0, irq_flag};
                default:    HRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_timer.sv
// Directed self-checking bench for ahb_timer; expectations follow the prescale
// build when AHB_TIMER_PRESCALE_EN is defined, otherwise the tick-every-cycle build.
module tb_ahb_timer;

    localparam logic [31:0] A_LOAD   = 32'h0;
    localparam logic [31:0] A_VALUE  = 32'h4;
    localparam logic [31:0] A_CTRL   = 32'h8;
    localparam logic [31:0] A_INTCLR = 32'hC;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        timer_irq;

    int checks   = 0;
    int failures = 0;

    ahb_timer dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .timer_irq (timer_irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] addrs [4];
        addrs = '{A_LOAD, A_VALUE, A_CTRL, A_INTCLR};
        checks++;
        if (timer_irq !== 1'b0 || HRDATA !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs irq=%b hrdata=%h expected irq=0 hrdata=0", timer_irq, HRDATA);
        end
        for (int i = 0; i < 4; i++) begin
            ahb_read(addrs[i], rd);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("FAIL reset_reg_%0h got=%h expected=00000000", addrs[i], rd);
            end
        end
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            failures++;
            $display("FAIL reset_resp hreadyout=%b hresp=%b expected 1/0", HREADYOUT, HRESP);
        end
    endtask

    task automatic test_periodic();
        logic [31:0] rd;
        logic [31:0] exp_seq [6];
        exp_seq = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd5};
        ahb_write(A_LOAD, 32'd5);
        ahb_read(A_VALUE, rd);
        checks++;
        if (rd !== 32'd5) begin
            failures++;
            $display("FAIL periodic_load_copy got=%0d expected=5", rd);
        end
        ahb_write(A_CTRL, 32'h11);
        for (int i = 0; i < 6; i++) begin
            ahb_read(A_VALUE, rd);
            checks++;
            if (rd !== exp_seq[i]) begin
                failures++;
                $display("FAIL periodic_value_%0d got=%0d expected=%0d", i, rd, exp_seq[i]);
            end
            if (i == 4) begin
                checks++;
                if (timer_irq !== 1'b0) begin
                    failures++;
                    $display("FAIL periodic_irq_early got=%b expected=0", timer_irq);
                end
            end
        end
        checks++;
        if (timer_irq !== 1'b1) begin
            failures++;
            $display("FAIL periodic_irq_rise got=%b expected=1", timer_irq);
        end
        ahb_write(A_INTCLR, 32'h1);
        checks++;
        if (timer_irq !== 1'b0) begin
            failures++;
            $display("FAIL periodic_intclr got=%b expected=0", timer_irq);
        end
        // Disable lands on a tick edge: that tick still decrements 2 -> 1.
        ahb_write(A_CTRL, 32'h0);
        ahb_read(A_VALUE, rd);
        checks++;
        if (rd !== 32'd1) begin
            failures++;
            $display("FAIL periodic_ctrl_tick got=%0d expected=1", rd);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        ahb_write(A_LOAD, 32'd3);
        ahb_write(A_CTRL, 32'h13);
        idle(8);
        ahb_read(A_VALUE, rd);
        checks++;
        if (rd !== 32'd0) begin
            failures++;
            $display("FAIL oneshot_value got=%0d expected=0", rd);
        end
        ahb_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h12) begin
            failures++;
            $display("FAIL oneshot_ctrl got=%h expected=00000012", rd);
        end
        ahb_read(A_INTCLR, rd);
        checks++;
        if (rd !== 32'h1 || timer_irq !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_flag got=%h irq=%b expected=1 irq=1", rd, timer_irq);
        end
        ahb_write(A_INTCLR, 32'h0);
        idle(4);
        checks++;
        if (timer_irq !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_clear got=%b expected=0", timer_irq);
        end
    endtask

    task automatic test_prescale();
        logic [31:0] rd;
        ahb_write(A_LOAD, 32'd2);
        ahb_write(A_CTRL, 32'h05);
`ifdef AHB_TIMER_PRESCALE_EN
        ahb_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h05) begin
            failures++;
            $display("FAIL prescale_ctrl got=%h expected=00000005", rd);
        end
        idle(13);
        ahb_read(A_VALUE, rd);
        checks++;
        if (rd !== 32'd2) begin
            failures++;
            $display("FAIL prescale_hold got=%0d expected=2", rd);
        end
        ahb_read(A_VALUE, rd);
        checks++;
        if (rd !== 32'd1) begin
            failures++;
            $display("FAIL prescale_tick1 got=%0d expected=1", rd);
        end
        idle(14);
        ahb_read(A_VALUE, rd);
        checks++;
        if (rd !== 32'd1) begin
            failures++;
            $display("FAIL prescale_hold2 got=%0d expected=1", rd);
        end
        ahb_read(A_VALUE, rd);
        checks++;
        if (rd !== 32'd0) begin
            failures++;
            $display("FAIL prescale_tick2 got=%0d expected=0", rd);
        end
`else
        ahb_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h01) begin
            failures++;
            $display("FAIL prescale_ctrl got=%h expected=00000001", rd);
        end
        ahb_read(A_VALUE, rd);
        checks++;
        if (rd !== 32'd0) begin
            failures++;
            $display("FAIL prescale_value0 got=%0d expected=0", rd);
        end
        ahb_read(A_VALUE, rd);
        checks++;
        if (rd !== 32'd2) begin
            failures++;
            $display("FAIL prescale_reload got=%0d expected=2", rd);
        end
        ahb_read(A_INTCLR, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("FAIL prescale_flag got=%h expected=00000001", rd);
        end
`endif
        ahb_write(A_CTRL, 32'h0);
        ahb_write(A_INTCLR, 32'h1);
    endtask

    task automatic test_collision();
        logic [31:0] rd;
        ahb_write(A_LOAD, 32'd10);
        ahb_write(A_CTRL, 32'h01);
        // LOAD write edge coincides with a tick: VALUE becomes 100, next tick gives 99.
        ahb_write(A_LOAD, 32'd100);
        ahb_read(A_VALUE, rd);
        checks++;
        if (rd !== 32'd99) begin
            failures++;
            $display("FAIL collision_load got=%0d expected=99", rd);
        end
        ahb_write(A_CTRL, 32'h0);
        ahb_read(A_VALUE, rd);
        checks++;
        if (rd !== 32'd97) begin
            failures++;
            $display("FAIL collision_ctrl got=%0d expected=97", rd);
        end
        ahb_read(A_INTCLR, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL collision_flag_pre got=%h expected=00000000", rd);
        end
        ahb_write(A_LOAD, 32'd3);
        ahb_write(A_CTRL, 32'h11);
        idle(2);
        // INTCLR write edge is the zero-crossing tick: the set must win.
        ahb_write(A_INTCLR, 32'h1);
        checks++;
        if (timer_irq !== 1'b1) begin
            failures++;
            $display("FAIL collision_intclr_irq got=%b expected=1", timer_irq);
        end
        ahb_read(A_INTCLR, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("FAIL collision_intclr_flag got=%h expected=00000001", rd);
        end
        ahb_write(A_CTRL, 32'h0);
        ahb_write(A_INTCLR, 32'h1);
        checks++;
        if (timer_irq !== 1'b0) begin
            failures++;
            $display("FAIL collision_cleanup got=%b expected=0", timer_irq);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = A_LOAD;
        @(posedge HCLK); #1;
        HWDATA = 32'h1234_5678; HWRITE = 1'b0; HADDR = A_VALUE;
        @(posedge HCLK); #1;
        rd = HRDATA;
        checks++;
        if (rd !== 32'h1234_5678) begin
            failures++;
            $display("FAIL b2b_read1 got=%h expected=12345678", rd);
        end
        HWRITE = 1'b1; HADDR = A_LOAD;
        @(posedge HCLK); #1;
        HWDATA = 32'hCAFE_0001; HWRITE = 1'b0; HADDR = A_VALUE;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        rd = HRDATA;
        checks++;
        if (rd !== 32'hCAFE_0001) begin
            failures++;
            $display("FAIL b2b_read2 got=%h expected=cafe0001", rd);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        logic [31:0] addrs [4];
        addrs = '{A_LOAD, A_VALUE, A_CTRL, A_INTCLR};
        ahb_write(A_LOAD, 32'd2);
        ahb_write(A_CTRL, 32'h11);
        idle(5);
        checks++;
        if (timer_irq !== 1'b1) begin
            failures++;
            $display("FAIL areset_irq_pre got=%b expected=1", timer_irq);
        end
        ahb_read(A_LOAD, rd);
        checks++;
        if (rd !== 32'd2) begin
            failures++;
            $display("FAIL areset_load_pre got=%0d expected=2", rd);
        end
        #2 HRESETn = 1'b0;
        #1;
        checks++;
        if (timer_irq !== 1'b0 || HRDATA !== 32'h0) begin
            failures++;
            $display("FAIL areset_immediate irq=%b hrdata=%h expected irq=0 hrdata=0", timer_irq, HRDATA);
        end
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ahb_read(addrs[i], rd);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("FAIL areset_reg_%0h got=%h expected=00000000", addrs[i], rd);
            end
        end
        checks++;
        if (timer_irq !== 1'b0 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            failures++;
            $display("FAIL areset_final irq=%b hreadyout=%b hresp=%b expected 0/1/0", timer_irq, HREADYOUT, HRESP);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HADDR   = '0;
        HTRANS  = 2'b00;
        HWRITE  = 1'b0;
        HSIZE   = 3'b010;
        HWDATA  = '0;
        HREADY  = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        test_reset();
        HRESETn = 1'b1;
        idle(1);
        test_reset();
        test_periodic();
        test_oneshot();
        test_prescale();
        test_collision();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
